dpram_be_param: RTL
===================

Name: dpram_be_param

Overview:
- Parametrised simple dual-port RAM: one write port with per-byte enables, one read port.
- Configurable data width, byte width, depth, read latency and read-during-write mode.
- Built-in clear sequencer zeroes the array after reset and on request, so the storage array has no reset and maps to block RAM.
- Used as a generic byte-maskable buffer by DMA and packet blocks in the datapath.

Parameters:
DATA_W, 32, data word width; must be a multiple of BYTE_W
BYTE_W, 8, bits per byte lane
DEPTH, 256, number of words; >= 2
RD_LAT, 1, read latency in cycles; legal values 1 or 2
WRITE_FIRST, 1, 1 = same-address read returns newly written bytes; 0 = returns old data
(derived) NB = DATA_W/BYTE_W, AW = $clog2(DEPTH)

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write request
byte_en  in  NB  lane enables; bit i covers wr_data[i*BYTE_W +: BYTE_W]
wr_addr  in  AW  write address
wr_data  in  DATA_W  write data
rd_en  in  1  read request
rd_addr  in  AW  read address
rd_data  out  DATA_W  read data, qualified by rd_valid
rd_valid  out  1  rd_data holds the result of a read issued RD_LAT cycles earlier
clear_req  in  1  one-cycle request to re-zero the whole array
init_busy  out  1  clear sequence in progress
wr_drop  out  1  one-cycle pulse: a write was discarded because init_busy was high

Behaviour:
- Reset values: rd_data=0, rd_valid=0, wr_drop=0, init_busy=1, FSM=CLEAR, clr_addr=0. Memory contents are not reset directly.
- FSM CLEAR: writes 0 to mem[clr_addr] each cycle and increments clr_addr. On the cycle clr_addr==DEPTH-1, moves to IDLE next cycle.
- init_busy is high for exactly DEPTH cycles after rst_n deasserts.
- FSM IDLE: init_busy=0. clear_req=1 moves to CLEAR next cycle with clr_addr=0.
- clear_req during CLEAR is ignored; the sequence does not restart.
- While init_busy=1:
  - wr_en is discarded; wr_drop pulses the next cycle if byte_en!=0.
  - rd_en is ignored; no rd_valid results.
- Write (IDLE only): on the clock edge, for each lane i with byte_en[i]=1, mem[wr_addr] lane i <= wr_data lane i. Other lanes are unchanged. byte_en==0 is a no-op.
- Read (IDLE only), RD_LAT=1: rd_data and rd_valid update on the edge after rd_en.
- Read, RD_LAT=2: an extra output register stage; rd_valid follows rd_en two edges later. Both pipeline stages advance every cycle (no stall).
- rd_data holds its last value when rd_valid=0.
- Same-cycle read and write to the same address:
  - WRITE_FIRST=1: returned word is per lane (byte_en[i] ? wr_data lane : old lane).
  - WRITE_FIRST=0: returned word is the old word.
  - Different addresses never interact.
- Address wrap: clr_addr stops at DEPTH-1. Out-of-range addresses (DEPTH not a power of two) are ignored on write and return 0 on read.
- Reset mid-operation: pipeline flushed (rd_valid=0); clear restarts from address 0.
- Reads in flight when clear_req is accepted still complete with pre-clear data.
- Elaboration check: fatal error if DATA_W%BYTE_W!=0 or RD_LAT not in {1,2}.

Decomposition:
- Package dpram_pkg holds:
  - state enum {CLEAR, IDLE};
  - function lane_merge(old, new, be) returning the per-lane merged word, used both for the write and for the write-first bypass;
  - localparam RD_LAT_MAX=2.
- Sub-module dpram_clear_seq: owns the FSM, clr_addr, init_busy and the clear_req handling. It outputs clr_we/clr_addr to the write mux in the top level.

Test Plan:
- Release reset with DEPTH=256 -> init_busy high for exactly 256 cycles; afterwards reading addresses 0, 128 and 255 gives 0x00000000 with rd_valid 1 cycle after rd_en.
- Write 0xAABBCCDD with be=4'b1111 to addr 5, then 0x11223344 with be=4'b0101 to addr 5; read addr 5 -> 0xAA22CC44.
- Same-cycle write of 0x11223344 with be=4'b1000 and read of addr 5 (old word 0xAA22CC44) -> 0x1122CC44 with WRITE_FIRST=1 and 0xAA22CC44 with WRITE_FIRST=0.
- RD_LAT=2: back-to-back reads of addrs 1, 2, 3 on consecutive cycles -> rd_valid high for 3 consecutive cycles starting 2 cycles after the first read, data in order.
- clear_req after memory is populated -> init_busy high for 256 cycles; a write issued during the clear gives a wr_drop pulse and no change to memory; afterwards all reads return 0.
- Assert rst_n low at clr_addr=100 mid-clear -> outputs return to reset values; after release, init_busy stays high for a full 256 cycles.

Source files
------------

// File: rtl/dpram_pkg.sv
// Shared types and helpers for the byte-maskable dual-port RAM.
package dpram_pkg;

  // Clear sequencer states: CLEAR zeroes the array, IDLE serves traffic.
  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  // Deepest read pipeline the RAM supports.
  localparam int RD_LAT_MAX = 2;

  // Widest word lane_merge can handle; callers zero-extend into this width.
  localparam int MERGE_W = 512;

  // Per-lane merge: bit j takes new_w when the enable of its lane is set,
  // otherwise keeps old_w. Used by the write path and the write-first bypass.
  function automatic logic [MERGE_W-1:0] lane_merge(
    input logic [MERGE_W-1:0] old_w,
    input logic [MERGE_W-1:0] new_w,
    input logic [MERGE_W-1:0] be,
    input int                 byte_w
  );
    logic [MERGE_W-1:0] res;
    res = old_w;
    for (int j = 0; j < MERGE_W; j++) begin
      if (be[j / byte_w]) res[j] = new_w[j];
    end
    return res;
  endfunction

endpackage

// File: rtl/dpram_be_param_if.sv
// Port bundle of the byte-maskable dual-port RAM.
// Handshake: there is no back-pressure. wr_en/rd_en are accepted on any
// rising edge where init_busy is low; rd_valid marks the single cycle in
// which rd_data carries the answer to a read issued RD_LAT cycles earlier.
// A write offered while init_busy is high is discarded and answered by a
// one-cycle wr_drop pulse.
interface dpram_be_param_if #(
  parameter int DATA_W = 32,
  parameter int BYTE_W = 8,
  parameter int DEPTH  = 256
);
  import dpram_pkg::*;

  localparam int NB = DATA_W / BYTE_W;
  localparam int AW = $clog2(DEPTH);

  logic              wr_en;
  logic [NB-1:0]     byte_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              clear_req;
  logic              init_busy;
  logic              wr_drop;
  state_t            dbg_state;
  logic [AW-1:0]     dbg_clr_addr;

  modport master (
    output wr_en, byte_en, wr_addr, wr_data, rd_en, rd_addr, clear_req,
    input  rd_data, rd_valid, init_busy, wr_drop, dbg_state, dbg_clr_addr
  );

  modport slave (
    input  wr_en, byte_en, wr_addr, wr_data, rd_en, rd_addr, clear_req,
    output rd_data, rd_valid, init_busy, wr_drop, dbg_state, dbg_clr_addr
  );

endinterface

// File: rtl/dpram_clear_seq.sv
// Clear sequencer: walks every address once after reset or on clear_req,
// telling the top level to write zero there, and holds init_busy meanwhile.
module dpram_clear_seq
  import dpram_pkg::*;
#(
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_req,
  output logic          init_busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output state_t        state
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  // Clear FSM; clr_addr parks at the last address once the sweep is done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CLEAR;
      clr_addr  <= '0;
      init_busy <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          if (clr_addr == LAST_ADDR) begin
            state     <= IDLE;
            init_busy <= 1'b0;
          end else begin
            clr_addr <= clr_addr + 1'b1;
          end
        end
        IDLE: begin
          if (clear_req) begin
            state     <= CLEAR;
            clr_addr  <= '0;
            init_busy <= 1'b1;
          end
        end
        default: begin
          state     <= CLEAR;
          clr_addr  <= '0;
          init_busy <= 1'b1;
        end
      endcase
    end
  end

  assign clr_we = (state == CLEAR);

endmodule

// File: rtl/dpram_be_param.sv
// Simple dual-port RAM with per-byte write enables, 1- or 2-cycle read
// latency, selectable read-during-write behaviour and a clear sequencer so
// the array itself needs no reset.
module dpram_be_param
  import dpram_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int BYTE_W      = 8,
  parameter int DEPTH       = 256,
  parameter int RD_LAT      = 1,
  parameter int WRITE_FIRST = 1
) (
  input logic             clk,
  input logic             rst_n,
  dpram_be_param_if.slave bus
);

  localparam int              AW      = $clog2(DEPTH);
  localparam logic [AW:0]     DEPTH_V = (AW + 1)'(DEPTH);

  if ((DATA_W % BYTE_W) != 0 || RD_LAT < 1 || RD_LAT > RD_LAT_MAX ||
      DATA_W > MERGE_W) begin : g_bad_cfg
    $fatal(1, "dpram_be_param: illegal DATA_W/BYTE_W/RD_LAT combination");
  end

  logic [DATA_W-1:0] mem [DEPTH];

  logic          init_busy;
  logic          clr_we;
  logic [AW-1:0] clr_addr;
  state_t        state;

  dpram_clear_seq #(.DEPTH(DEPTH)) u_clear_seq (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_req (bus.clear_req),
    .init_busy (init_busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr),
    .state     (state)
  );

  logic              wr_in_range;
  logic              rd_in_range;
  logic              wr_ok;
  logic              rd_ok;
  logic [DATA_W-1:0] wr_old;
  logic [DATA_W-1:0] wr_word;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_result;

  // Port qualification, write merge and the same-address read bypass.
  always_comb begin
    wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_V);
    rd_in_range = ({1'b0, bus.rd_addr} < DEPTH_V);
    wr_ok       = bus.wr_en && !init_busy && wr_in_range && (|bus.byte_en);
    rd_ok       = bus.rd_en && !init_busy;
    wr_old      = wr_in_range ? mem[bus.wr_addr] : '0;
    rd_word     = rd_in_range ? mem[bus.rd_addr] : '0;
    wr_word     = DATA_W'(lane_merge(MERGE_W'(wr_old), MERGE_W'(bus.wr_data),
                                     MERGE_W'(bus.byte_en), BYTE_W));
    rd_result   = rd_word;
    if (WRITE_FIRST != 0 && wr_ok && bus.wr_addr == bus.rd_addr) begin
      rd_result = wr_word;
    end
  end

  // Storage write port: the clear sweep owns the port while it runs.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= '0;
    end else if (wr_ok) begin
      mem[bus.wr_addr] <= wr_word;
    end
  end

  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;

  // First read stage; data holds its value when no read is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= rd_ok;
      if (rd_ok) s1_data <= rd_result;
    end
  end

  if (RD_LAT == 1) begin : g_lat1
    assign bus.rd_data  = s1_data;
    assign bus.rd_valid = s1_valid;
  end else begin : g_lat2
    logic              s2_valid;
    logic [DATA_W-1:0] s2_data;

    // Extra output stage; advances every cycle, holds data between reads.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_valid <= 1'b0;
        s2_data  <= '0;
      end else begin
        s2_valid <= s1_valid;
        if (s1_valid) s2_data <= s1_data;
      end
    end

    assign bus.rd_data  = s2_data;
    assign bus.rd_valid = s2_valid;
  end

  logic wr_drop_q;

  // Flag writes that arrive while the clear sweep is running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_drop_q <= 1'b0;
    end else begin
      wr_drop_q <= bus.wr_en && init_busy && (|bus.byte_en);
    end
  end

  assign bus.wr_drop      = wr_drop_q;
  assign bus.init_busy    = init_busy;
  assign bus.dbg_state    = state;
  assign bus.dbg_clr_addr = clr_addr;

endmodule
